des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have no parameters; all tables and widths are fixed constants.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL have port i_start, input, 1 bit: load i_key/i_decrypt and begin a schedule; honoured only when idle.
REQ-005 SHALL have port i_decrypt, input, 1 bit: 0 = issue K1..K16; 1 = issue K16..K1.
REQ-006 SHALL have port i_key, input, 64 bits: DES key, bit 63 = FIPS bit 1; parity bits ignored.
REQ-007 SHALL have port i_next, input, 1 bit: consumer ready; transfer = o_valid && i_next.
REQ-008 SHALL have port o_subkey, output, 48 bits: current round subkey, bit 47 = FIPS bit 1.
REQ-009 SHALL have port o_valid, output, 1 bit: o_subkey/o_round valid.
REQ-010 SHALL have port o_round, output, 4 bits: issue index 0..15 (issue order, not key number).
REQ-011 SHALL have port o_busy, output, 1 bit: schedule in progress.
REQ-012 SHALL have port o_done, output, 1 bit: one-cycle pulse after the 16th transfer.

Function
REQ-013 SHALL apply PC-1 to i_key on the i_start cycle, producing 28-bit halves C0, D0.
REQ-014 SHALL, in encrypt mode, load C,D = rotl(C0,1), rotl(D0,1), so that PC-2(C,D) = K1.
REQ-015 SHALL, in decrypt mode, load C,D = C0, D0 unrotated, so that PC-2(C,D) = K16 (total rotation 28).
REQ-016 SHALL drive o_subkey = PC-2(C,D) combinationally from the C,D registers.
REQ-017 SHALL implement FSM IDLE -> ISSUE on i_start in IDLE; o_valid = o_busy = 1 in ISSUE.
REQ-018 SHALL assert o_valid on the cycle after i_start (latency 1), with o_round = 0.
REQ-019 SHALL, on each transfer, increment o_round and rotate C,D: encrypt rotl by SHIFT[o_round+1]; decrypt rotr by SHIFT[15-o_round].
REQ-020 SHALL use SHIFT[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 SHALL hold o_subkey, o_round and o_valid stable while o_valid && !i_next.
REQ-022 SHALL, on a transfer with o_round = 15, enter IDLE and pulse o_done for exactly one cycle; o_valid = 0 in that cycle.
REQ-023 SHALL ignore i_start while in ISSUE, including in the cycle of the final transfer.
REQ-024 SHALL ignore i_next while in IDLE.
REQ-025 SHALL sample i_key and i_decrypt only in the i_start cycle; later changes have no effect.
REQ-026 SHALL leave C,D at their final value in IDLE; o_subkey is don't-care when o_valid = 0.

Reset
REQ-027 SHALL, when i_rst_n = 0 at a clock edge, force IDLE, C = D = 0, o_round = 0, o_valid = 0, o_busy = 0 and o_done = 0; o_subkey then reads PC-2(0) = 0.
REQ-028 SHALL let reset override any in-progress schedule and i_start in the same cycle; no o_done is produced for an aborted schedule.

Structure
REQ-029 SHALL take the PC-1 table, PC-2 table, SHIFT schedule and FSM state encodings from a shared des_pkg, reused by the round engine.
REQ-030 SHALL instantiate PC-2 as sub-module des_pc2 (56 in, 48 out, pure wiring).

Verification
REQ-031 SHALL verify encrypt order: key 133457799BBCDFF1, i_decrypt = 0, i_next held 1 -> round 0 subkey 1B02EFFC7072, round 15 subkey CB3D8B0E17F5, o_done pulses 17 cycles after i_start.
REQ-032 SHALL verify decrypt order: same key, i_decrypt = 1 -> round 0 subkey CB3D8B0E17F5, round 15 subkey 1B02EFFC7072; all 16 subkeys equal the encrypt sequence reversed.
REQ-033 SHALL verify backpressure: i_next toggled randomly -> subkeys and rounds are stable while stalled, with no skipped or duplicated round.
REQ-034 SHALL verify start-while-busy: i_start pulsed with a different key at round 7 and at the final transfer -> the sequence is unchanged and no restart occurs.
REQ-035 SHALL verify reset mid-schedule: i_rst_n = 0 at round 9 -> the next cycle shows o_valid = 0, o_busy = 0, o_round = 0 and no o_done; a new i_start then runs a full schedule.
REQ-036 SHALL verify parity independence: key 133457799BBCDFF1 with every byte LSB flipped -> the subkey sequence is identical to REQ-031.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, rotation schedule, FSM states and a 28-bit rotate helper.
package des_pkg;
    typedef enum logic {IDLE, ISSUE} state_t;

    // Entries are FIPS bit numbers (1 = MSB) of the source vector.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n, input logic left);
        return left ? (n == 2'd2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]})
                    : (n == 2'd2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]});
    endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, 56-bit C||D to 48-bit round subkey (pure wiring).
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);
    logic unused_cd;

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47 - i] = cd[56 - PC2[i]];
    end

    // PC-2 drops eight of the 56 bits.
    assign unused_cd = ^cd;
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: DES round-key generator issuing K1..K16 (or K16..K1) with valid/ready handshake.
module des_key_sched
    import des_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    input  logic        i_next,
    output logic [47:0] o_subkey,
    output logic        o_valid,
    output logic [3:0]  o_round,
    output logic        o_busy,
    output logic        o_done
);
    state_t      state, state_nx;
    logic [27:0] c, d;
    logic [55:0] cd0;
    logic [3:0]  round;
    logic [1:0]  sh;
    logic        dec, done, xfer, load, unused_key;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign cd0[55 - i] = i_key[64 - PC1[i]];
    end

    // Parity bits never reach PC-1's output.
    assign unused_key = ^i_key;
    assign load = state == IDLE && i_start;
    assign xfer = state == ISSUE && i_next;
    assign sh = dec ? SHIFT[4'd15 - round] : SHIFT[round + 4'd1];

    always_comb begin
        state_nx = state;
        if (load) state_nx = ISSUE;
        else if (xfer && round == 4'd15) state_nx = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            dec   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= xfer && round == 4'd15;
            if (load) begin
                dec   <= i_decrypt;
                round <= '0;
                c     <= i_decrypt ? cd0[55:28] : rot28(cd0[55:28], 2'd1, 1'b1);
                d     <= i_decrypt ? cd0[27:0] : rot28(cd0[27:0], 2'd1, 1'b1);
            end else if (xfer) begin
                round <= round + 4'd1;
                c     <= rot28(c, sh, !dec);
                d     <= rot28(d, sh, !dec);
            end
        end
    end

    des_pc2 u_pc2 (.cd({c, d}), .subkey(o_subkey));

    assign o_valid = state == ISSUE;
    assign o_busy  = state == ISSUE;
    assign o_round = round;
    assign o_done  = done;
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: scoreboard bench for des_key_sched against the FIPS-46 worked-example subkeys.
module tb_des_key_sched;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_decrypt = 1'b0, i_next = 1'b0;
    logic [63:0] i_key = '0;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;
    logic        o_valid, o_busy, o_done;
    int          checks = 0, errors = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] EK [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [47:0] sb_key [$];
    logic [3:0]  sb_rnd [$];
    logic [47:0] ek, pk;
    logic [3:0]  er, pr;
    logic        stalled = 1'b0;

    des_key_sched dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_decrypt(i_decrypt),
        .i_key(i_key), .i_next(i_next), .o_subkey(o_subkey), .o_valid(o_valid),
        .o_round(o_round), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Transfers are judged at the falling edge, where i_next already holds the value the next rising edge samples.
    always @(negedge i_clk) begin
        if (i_rst_n && stalled) begin
            checks++;
            if (o_valid !== 1'b1 || o_subkey !== pk || o_round !== pr) begin
                errors++;
                $display("FAIL stall_hold: valid=%b key=%h round=%0d, required valid=1 key=%h round=%0d",
                         o_valid, o_subkey, o_round, pk, pr);
            end
        end
        if (i_rst_n && o_valid && i_next) begin
            checks++;
            if (sb_key.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: round=%0d key=%h, required no transfer", o_round, o_subkey);
            end else begin
                ek = sb_key.pop_front();
                er = sb_rnd.pop_front();
                if (o_subkey !== ek || o_round !== er) begin
                    errors++;
                    $display("FAIL subkey: round=%0d key=%h, required round=%0d key=%h", o_round, o_subkey, er, ek);
                end
            end
        end
        stalled <= i_rst_n && o_valid && !i_next;
        pk <= o_subkey;
        pr <= o_round;
    end

    task step;
        @(posedge i_clk);
        #1;
    endtask

    task start(input logic [63:0] key, input logic dec);
        i_key = key;
        i_decrypt = dec;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        i_key = ~key;
        i_decrypt = ~dec;
        for (int i = 0; i < 16; i++) begin
            sb_key.push_back(dec ? EK[15 - i] : EK[i]);
            sb_rnd.push_back(4'(i));
        end
    endtask

    task wait_done(input bit rnd, output int cyc);
        cyc = 1;
        while (!o_done && cyc < 300) begin
            if (rnd) i_next = 1'($urandom_range(0, 1));
            step;
            cyc++;
        end
        if (!o_done) cyc = -1;
    endtask

    task test_reset;
        i_rst_n = 1'b0;
        i_next = 1'b1;
        i_start = 1'b1;
        step;
        step;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_round !== 4'd0 || o_subkey !== 48'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b round=%0d key=%h, required all zero",
                     o_valid, o_busy, o_done, o_round, o_subkey);
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        step;
        step;
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0 || o_round !== 4'd0) begin
            errors++;
            $display("FAIL idle_next_ignored: valid=%b done=%b round=%0d, required 0 0 0", o_valid, o_done, o_round);
        end
    endtask

    task test_order(input logic dec, input logic [63:0] key);
        int cyc;
        i_next = 1'b1;
        start(key, dec);
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_round !== 4'd0 || o_subkey !== (dec ? EK[15] : EK[0])) begin
            errors++;
            $display("FAIL first_subkey dec=%b: valid=%b busy=%b round=%0d key=%h, required 1 1 0 %h",
                     dec, o_valid, o_busy, o_round, o_subkey, dec ? EK[15] : EK[0]);
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL done_latency dec=%b: got %0d cycles, required 17", dec, cyc);
        end
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle dec=%b: valid=%b busy=%b, required 0 0", dec, o_valid, o_busy);
        end
        checks++;
        if (sb_key.size() != 0) begin
            errors++;
            $display("FAIL sb_empty dec=%b: %0d left, required 0", dec, sb_key.size());
        end
        step;
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse dec=%b: done=%b, required 0", dec, o_done);
        end
    endtask

    task test_encrypt;
        test_order(1'b0, KEY);
    endtask

    task test_decrypt;
        test_order(1'b1, KEY);
    endtask

    task test_parity;
        test_order(1'b0, KEY ^ 64'h0101010101010101);
    endtask

    task test_backpressure;
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            i_next = 1'b0;
            start(KEY, 1'(pass));
            wait_done(1'b1, cyc);
            checks++;
            if (cyc < 17 || sb_key.size() != 0) begin
                errors++;
                $display("FAIL backpressure pass=%0d: cycles=%0d left=%0d, required >=17 and 0", pass, cyc, sb_key.size());
            end
        end
        i_next = 1'b1;
        step;
    endtask

    task test_start_busy;
        int cyc;
        i_next = 1'b1;
        start(KEY, 1'b0);
        cyc = 1;
        while (!o_done && cyc < 300) begin
            i_start = o_valid && (o_round == 4'd7 || o_round == 4'd15);
            i_key = ~KEY;
            i_decrypt = 1'b1;
            step;
            cyc++;
        end
        i_start = 1'b0;
        checks++;
        if (cyc !== 17 || sb_key.size() != 0) begin
            errors++;
            $display("FAIL start_busy_seq: cycles=%0d left=%0d, required 17 and 0", cyc, sb_key.size());
        end
        step;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_restart: valid=%b busy=%b, required 0 0", o_valid, o_busy);
        end
    endtask

    task test_reset_mid;
        int cyc;
        i_next = 1'b1;
        start(KEY, 1'b0);
        cyc = 1;
        while (o_round != 4'd9 && cyc < 40) begin
            step;
            cyc++;
        end
        checks++;
        if (o_round !== 4'd9 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_round9: round=%0d valid=%b, required 9 1", o_round, o_valid);
        end
        i_rst_n = 1'b0;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_round !== 4'd0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b round=%0d done=%b, required 0 0 0 0",
                     o_valid, o_busy, o_round, o_done);
        end
        i_rst_n = 1'b1;
        sb_key.delete();
        sb_rnd.delete();
        step;
        checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b valid=%b, required 0 0", o_done, o_valid);
        end
        start(KEY, 1'b0);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 17 || sb_key.size() != 0) begin
            errors++;
            $display("FAIL reset_rerun: cycles=%0d left=%0d, required 17 and 0", cyc, sb_key.size());
        end
        step;
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_start_busy;
        test_reset_mid;
        test_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
